// File: rtl/egg_timer_ctrl.sv
// Egg-timer control FSM: field setting, run/pause, and a timed end-of-count flash phase.
// All outputs come from registers; buttons are active low and act on release.
module egg_timer_ctrl #(
  parameter int unsigned NUM_FIELDS    = 2,
  parameter int unsigned FIELD_W       = 1,
  parameter int unsigned FLASH_CYCLES  = 25_000_000,
  parameter int unsigned FLASH_TOGGLES = 6,
  parameter int unsigned CNT_W         = 25
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               key_clr,
  input  logic               key_sel,
  input  logic               key_run,
  input  logic               finish,
  output logic [3:0]         state,
  output logic [FIELD_W-1:0] field,
  output logic               set_en,
  output logic               run_en,
  output logic               flash_on,
  output logic               done
);

  localparam int unsigned TcW = (FLASH_TOGGLES > 1) ? $clog2(FLASH_TOGGLES) : 1;
  localparam logic [FIELD_W-1:0] FieldLast = FIELD_W'(NUM_FIELDS - 1);
  localparam logic [CNT_W-1:0]   HcLast    = CNT_W'(FLASH_CYCLES - 1);
  localparam logic [TcW-1:0]     TcLast    =
      TcW'((FLASH_TOGGLES == 0) ? 32'd0 : FLASH_TOGGLES - 1);
  localparam logic [TcW-1:0]     TcMax     = '1;

  typedef enum logic [3:0] {
    StIdle     = 4'd0,
    StSet      = 4'd1,
    StSetRel   = 4'd2,
    StReady    = 4'd3,
    StReadyRel = 4'd4,
    StRun      = 4'd5,
    StRunRel   = 4'd6,
    StFlash    = 4'd7,
    StAckRel   = 4'd8
  } state_e;

  state_e             state_q, state_d;
  logic [FIELD_W-1:0] field_q, field_d;
  logic [CNT_W-1:0]   hc_q, hc_d;
  logic [TcW-1:0]     tc_q, tc_d;
  logic               flash_q, flash_d;
  logic               done_q, done_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      field_q <= '0;
      hc_q    <= '0;
      tc_q    <= '0;
      flash_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      field_q <= field_d;
      hc_q    <= hc_d;
      tc_q    <= tc_d;
      flash_q <= flash_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    field_d = field_q;
    hc_d    = hc_q;
    tc_d    = tc_q;
    flash_d = flash_q;
    done_d  = 1'b0;
    if (!key_clr) begin
      state_d = StIdle;
      field_d = '0;
      hc_d    = '0;
      tc_d    = '0;
      flash_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StSet;
          field_d = '0;
        end
        StSet: begin
          if (!key_sel) state_d = StSetRel;
        end
        StSetRel: begin
          if (key_sel) begin
            if (field_q == FieldLast) begin
              state_d = StReady;
            end else begin
              field_d = field_q + FIELD_W'(1);
              state_d = StSet;
            end
          end
        end
        StReady: begin
          // Re-editing parks on the last field so the release lands back in READY.
          if (!key_run) begin
            state_d = StReadyRel;
          end else if (!key_sel) begin
            state_d = StSetRel;
            field_d = FieldLast;
          end
        end
        StReadyRel: begin
          if (key_run) state_d = StRun;
        end
        StRun: begin
          if (!key_run) begin
            state_d = StRunRel;
          end else if (finish) begin
            state_d = StFlash;
            flash_d = 1'b1;
            hc_d    = '0;
            tc_d    = '0;
          end
        end
        StRunRel: begin
          if (key_run) state_d = StReady;
        end
        StFlash: begin
          if (!key_run) begin
            state_d = StAckRel;
            flash_d = 1'b0;
            hc_d    = '0;
          end else if (hc_q == HcLast) begin
            hc_d = '0;
            if (FLASH_TOGGLES != 0 && tc_q == TcLast) begin
              state_d = StIdle;
              flash_d = 1'b0;
              done_d  = 1'b1;
            end else begin
              flash_d = ~flash_q;
              if (tc_q != TcMax) tc_d = tc_q + TcW'(1);
            end
          end else begin
            hc_d = hc_q + CNT_W'(1);
          end
        end
        StAckRel: begin
          if (key_run) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    state    = state_q;
    field    = field_q;
    set_en   = (state_q == StSet);
    run_en   = (state_q == StRun);
    flash_on = flash_q;
    done     = done_q;
  end

endmodule

// File: tb/tb_egg_timer_ctrl.sv
// Bench for egg_timer_ctrl: one instance with auto-exit flash, one with acknowledge-only flash,
// both fed the same stimulus and checked against a cycle-count reference model.
module tb_egg_timer_ctrl;

  localparam int NF = 3;
  localparam int FW = 2;
  localparam int FC = 4;
  localparam int FT = 4;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0, key_clr = 1'b1, key_sel = 1'b1, key_run = 1'b1, finish = 1'b0;
  logic [3:0] st_a, st_b;
  logic [FW-1:0] fl_a, fl_b;
  logic se_a, se_b, re_a, re_b, fo_a, fo_b, dn_a, dn_b;

  always #5 clk = ~clk;

  egg_timer_ctrl #(
    .NUM_FIELDS(NF), .FIELD_W(FW), .FLASH_CYCLES(FC), .FLASH_TOGGLES(FT), .CNT_W(CW)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .key_clr(key_clr), .key_sel(key_sel), .key_run(key_run),
    .finish(finish), .state(st_a), .field(fl_a), .set_en(se_a), .run_en(re_a),
    .flash_on(fo_a), .done(dn_a)
  );

  egg_timer_ctrl #(
    .NUM_FIELDS(NF), .FIELD_W(FW), .FLASH_CYCLES(FC), .FLASH_TOGGLES(0), .CNT_W(CW)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .key_clr(key_clr), .key_sel(key_sel), .key_run(key_run),
    .finish(finish), .state(st_b), .field(fl_b), .set_en(se_b), .run_en(re_b),
    .flash_on(fo_b), .done(dn_b)
  );

  // Flash is modelled by cycles elapsed since entry, not by half-period/toggle counters.
  typedef struct {
    int st;
    int fld;
    int e;
    bit done;
  } model_t;

  typedef struct {
    bit rst, clr, sel, run, fin;
    int st, fld;
    bit fo, dn;
  } vec_t;

  model_t ma, mb;
  int n_chk = 0;
  int n_fail = 0;

  function automatic model_t step(model_t m, int ft, bit rst, bit clr, bit sel, bit run,
                                  bit fin);
    model_t n = m;
    n.done = 1'b0;
    if (!rst || !clr) begin
      n.st = 0; n.fld = 0; n.e = 0;
    end else begin
      case (m.st)
        0: begin n.st = 1; n.fld = 0; end
        1: if (!sel) n.st = 2;
        2: if (sel) begin
          if (m.fld == NF - 1) n.st = 3;
          else begin n.fld = m.fld + 1; n.st = 1; end
        end
        3: if (!run) n.st = 4;
           else if (!sel) begin n.st = 2; n.fld = NF - 1; end
        4: if (run) n.st = 5;
        5: if (!run) n.st = 6;
           else if (fin) begin n.st = 7; n.e = 0; end
        6: if (run) n.st = 3;
        7: if (!run) n.st = 8;
           else begin
             n.e = m.e + 1;
             if (ft != 0 && n.e == ft * FC) begin n.st = 0; n.done = 1'b1; end
           end
        8: if (run) n.st = 0;
        default: n.st = 0;
      endcase
    end
    return n;
  endfunction

  function automatic bit m_flash(model_t m);
    return (m.st == 7) && (((m.e / FC) % 2) == 0);
  endfunction

  function automatic vec_t mk(bit rst, bit clr, bit sel, bit run, bit fin, int st, int fld,
                              bit fo, bit dn);
    vec_t v;
    v.rst = rst; v.clr = clr; v.sel = sel; v.run = run; v.fin = fin;
    v.st = st; v.fld = fld; v.fo = fo; v.dn = dn;
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_models();
    chk("a.state", st_a, ma.st);
    chk("a.field", fl_a, ma.fld);
    chk("a.set_en", se_a, ma.st == 1);
    chk("a.run_en", re_a, ma.st == 5);
    chk("a.flash_on", fo_a, m_flash(ma));
    chk("a.done", dn_a, ma.done);
    chk("b.state", st_b, mb.st);
    chk("b.field", fl_b, mb.fld);
    chk("b.set_en", se_b, mb.st == 1);
    chk("b.run_en", re_b, mb.st == 5);
    chk("b.flash_on", fo_b, m_flash(mb));
    chk("b.done", dn_b, mb.done);
  endtask

  task automatic cyc();
    @(posedge clk);
    ma = step(ma, FT, rst_n, key_clr, key_sel, key_run, finish);
    mb = step(mb, 0, rst_n, key_clr, key_sel, key_run, finish);
    #1;
    compare_models();
  endtask

  task automatic set_in(bit r, bit c, bit s, bit k, bit f);
    rst_n = r; key_clr = c; key_sel = s; key_run = k; finish = f;
  endtask

  task automatic expect_a(string name, int st, int fld, bit fo, bit dn);
    chk({name, ".state"}, st_a, st);
    chk({name, ".field"}, fl_a, fld);
    chk({name, ".flash_on"}, fo_a, fo);
    chk({name, ".done"}, dn_a, dn);
  endtask

  // From SET with field 0: walk all fields, then start the countdown.
  task automatic drive_to_run();
    for (int i = 0; i < NF; i++) begin
      set_in(1, 1, 0, 1, 0); cyc();
      set_in(1, 1, 1, 1, 0); cyc();
    end
    set_in(1, 1, 1, 0, 0); cyc();
    set_in(1, 1, 1, 1, 0); cyc();
    chk("to_run.state", st_a, 5);
  endtask

  vec_t tbl[24];

  initial begin
    ma = '{st: 0, fld: 0, e: 0, done: 1'b0};
    mb = ma;

    tbl[0]  = mk(0, 1, 1, 1, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 1, 1, 0, 0, 0, 0, 0);
    tbl[2]  = mk(1, 1, 1, 1, 0, 1, 0, 0, 0);
    tbl[3]  = mk(1, 1, 0, 1, 0, 2, 0, 0, 0);
    tbl[4]  = mk(1, 1, 1, 1, 0, 1, 1, 0, 0);
    tbl[5]  = mk(1, 1, 0, 1, 0, 2, 1, 0, 0);
    tbl[6]  = mk(1, 1, 1, 1, 0, 1, 2, 0, 0);
    tbl[7]  = mk(1, 1, 0, 1, 0, 2, 2, 0, 0);
    tbl[8]  = mk(1, 1, 1, 1, 0, 3, 2, 0, 0);
    tbl[9]  = mk(1, 1, 1, 0, 0, 4, 2, 0, 0);
    tbl[10] = mk(1, 1, 1, 1, 0, 5, 2, 0, 0);
    tbl[11] = mk(1, 1, 1, 1, 0, 5, 2, 0, 0);
    tbl[12] = mk(1, 1, 1, 0, 0, 6, 2, 0, 0);
    tbl[13] = mk(1, 1, 1, 1, 0, 3, 2, 0, 0);
    tbl[14] = mk(1, 1, 0, 1, 0, 2, 2, 0, 0);
    tbl[15] = mk(1, 1, 1, 1, 0, 3, 2, 0, 0);
    tbl[16] = mk(1, 1, 0, 0, 0, 4, 2, 0, 0);
    tbl[17] = mk(1, 1, 1, 1, 0, 5, 2, 0, 0);
    tbl[18] = mk(1, 1, 1, 0, 1, 6, 2, 0, 0);
    tbl[19] = mk(1, 1, 1, 0, 1, 6, 2, 0, 0);
    tbl[20] = mk(1, 1, 1, 1, 1, 3, 2, 0, 0);
    tbl[21] = mk(1, 1, 1, 0, 0, 4, 2, 0, 0);
    tbl[22] = mk(1, 1, 1, 1, 0, 5, 2, 0, 0);
    tbl[23] = mk(1, 1, 1, 1, 1, 7, 2, 1, 0);

    for (int i = 0; i < 24; i++) begin
      set_in(tbl[i].rst, tbl[i].clr, tbl[i].sel, tbl[i].run, tbl[i].fin);
      cyc();
      expect_a($sformatf("vec%0d", i), tbl[i].st, tbl[i].fld, tbl[i].fo, tbl[i].dn);
      chk($sformatf("vec%0d.set_en", i), se_a, tbl[i].st == 1);
      chk($sformatf("vec%0d.run_en", i), re_a, tbl[i].st == 5);
    end

    // Auto-exit flash: entered at t+1 above; walk t+2..t+16.
    set_in(1, 1, 1, 1, 0);
    for (int k = 2; k <= FT * FC; k++) begin
      cyc();
      expect_a($sformatf("flash_t%0d", k), 7, 2, ((k - 1) / FC) % 2 == 0, 0);
    end
    cyc();
    expect_a("flash_exit", 0, 2, 0, 1);
    cyc();
    expect_a("flash_after", 1, 0, 0, 0);

    // Acknowledge-only flash keeps going until key_run is pressed.
    for (int k = 0; k < 100; k++) cyc();
    chk("ack.long_state", st_b, 7);
    set_in(1, 1, 1, 0, 0); cyc();
    chk("ack.press_state", st_b, 8);
    chk("ack.press_flash", fo_b, 0);
    chk("ack.a_ignores_run", st_a, 1);
    set_in(1, 1, 1, 1, 0); cyc();
    chk("ack.rel_state", st_b, 0);
    chk("ack.rel_done", dn_b, 0);
    cyc();
    chk("ack.set_state", st_b, 1);

    // Clear during SET_REL with a nonzero field, held for 10 cycles.
    set_in(1, 1, 0, 1, 0); cyc();
    set_in(1, 1, 1, 1, 0); cyc();
    set_in(1, 1, 0, 1, 0); cyc();
    expect_a("setrel", 2, 1, 0, 0);
    set_in(1, 0, 1, 1, 0); cyc();
    expect_a("clr_setrel", 0, 0, 0, 0);
    for (int k = 0; k < 10; k++) cyc();
    expect_a("clr_hold", 0, 0, 0, 0);
    set_in(1, 1, 1, 1, 0); cyc();
    expect_a("clr_release", 1, 0, 0, 0);

    // Clear during RUN_REL.
    drive_to_run();
    set_in(1, 1, 1, 0, 0); cyc();
    chk("runrel.state", st_a, 6);
    set_in(1, 0, 1, 1, 0); cyc();
    expect_a("clr_runrel", 0, 0, 0, 0);
    set_in(1, 1, 1, 1, 0); cyc();

    // Clear mid-FLASH: no done pulse afterwards.
    drive_to_run();
    set_in(1, 1, 1, 1, 1); cyc();
    set_in(1, 1, 1, 1, 0);
    for (int k = 0; k < 5; k++) cyc();
    set_in(1, 0, 1, 1, 0); cyc();
    expect_a("clr_flash", 0, 0, 0, 0);
    set_in(1, 1, 1, 1, 0);
    for (int k = 0; k < 20; k++) begin
      cyc();
      chk("clr_flash.no_done", dn_a, 0);
    end

    // Reset mid-FLASH.
    set_in(1, 1, 1, 1, 0);
    drive_to_run();
    set_in(1, 1, 1, 1, 1); cyc();
    set_in(1, 1, 1, 1, 0); cyc(); cyc();
    set_in(0, 1, 1, 1, 0); cyc();
    expect_a("rst_flash", 0, 0, 0, 0);
    set_in(1, 1, 1, 1, 0);
    for (int k = 0; k < 20; k++) begin
      cyc();
      chk("rst_flash.no_done", dn_a, 0);
    end

    // Random phases: busy buttons, then sparse buttons so flash can time out.
    for (int k = 0; k < 2000; k++) begin
      set_in($urandom_range(63) != 0, $urandom_range(31) != 0, $urandom_range(2) != 0,
             $urandom_range(2) != 0, $urandom_range(7) == 0);
      cyc();
    end
    for (int k = 0; k < 4000; k++) begin
      set_in($urandom_range(255) != 0, $urandom_range(127) != 0, $urandom_range(3) != 0,
             $urandom_range(15) != 0, $urandom_range(3) == 0);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/egg_timer_ctrl.md
# egg_timer_ctrl

Parametrised control FSM for the egg-timer datapath, successor to the two-field (seconds/minutes) controller. It sequences an arbitrary number of set fields, run/pause, and an end-of-count flash phase with its own half-period timer, toggle limit and acknowledge. It sits between the debounced push-button inputs and the countdown/display datapath, which consumes `state`, `field`, `set_en`, `run_en` and `flash_on`.

## Interface
- `NUM_FIELDS`, default 2: number of settable fields (field 0 = seconds, field 1 = minutes, ...); ≥ 1.
- `FIELD_W`, default 1: width of `field`; 2^FIELD_W ≥ NUM_FIELDS.
- `FLASH_CYCLES`, default 25_000_000: clk cycles per flash half-period; ≥ 1.
- `FLASH_TOGGLES`, default 6: half-periods before auto-exit from FLASH; 0 = flash until acknowledged.
- `CNT_W`, default 25: width of the half-period counter; 2^CNT_W ≥ FLASH_CYCLES.

Ports:
- `clk` in 1: system clock; all logic on posedge.
- `rst_n` in 1: synchronous, active-low reset.
- `key_clr` in 1: clear button, active low (0 = pressed).
- `key_sel` in 1: field-select/advance button, active low.
- `key_run` in 1: start/pause/acknowledge button, active low.
- `finish` in 1: countdown reached zero; level, sampled only in RUN.
- `state` out 4: current state code.
- `field` out FIELD_W: field being set.
- `set_en` out 1: datapath may edit `field`.
- `run_en` out 1: datapath decrements this cycle.
- `flash_on` out 1: display blank/flash phase.
- `done` out 1: one-cycle pulse on auto-exit from FLASH.

## Operation
- State codes: IDLE=0, SET=1, SET_REL=2, READY=3, READY_REL=4, RUN=5, RUN_REL=6, FLASH=7, ACK_REL=8. Codes 9–15 go to IDLE on the next clk.
- Button actions commit on release. A press moves to a *_REL state, and the release performs the transition.
- Priority (highest first): `rst_n`=0, then `key_clr`=0, then per-state rules. Either of the first two forces IDLE, `field`=0, `flash_on`=0, both counters 0, `done`=0.
- IDLE: when `key_clr`=1, go to SET with `field`=0.
- SET: when `key_sel`=0, go to SET_REL.
- SET_REL: when `key_sel`=1:
  - if `field`==NUM_FIELDS-1, go to READY;
  - otherwise increment `field` and go to SET.
- `key_run` is ignored in SET and SET_REL.
- READY: when `key_run`=0, go to READY_REL. When `key_sel`=0, go to SET_REL with `field` set to NUM_FIELDS-1, so the release re-enters READY. If both are pressed in the same cycle, `key_run` wins.
- READY_REL: when `key_run`=1, go to RUN.
- RUN: when `key_run`=0, go to RUN_REL (pause). Otherwise, when `finish`=1, go to FLASH. A simultaneous press and `finish` takes RUN_REL.
- RUN_REL: when `key_run`=1, go to READY. `finish` is ignored.
- FLASH:
  - Entry sets `flash_on`=1, half-period count `hc`=0, toggle count `tc`=0.
  - Each cycle `hc` increments.
  - When `hc`==FLASH_CYCLES-1: `hc` goes to 0. If FLASH_TOGGLES≠0 and `tc`==FLASH_TOGGLES-1, go to IDLE with `flash_on`=0 and `done`=1. Otherwise invert `flash_on` and increment `tc`.
  - `key_run`=0 goes to ACK_REL with `flash_on`=0. This takes precedence over the timer.
  - With FLASH_TOGGLES=0, `tc` saturates and is unused.
- ACK_REL: when `key_run`=1, go to IDLE. `done` is not pulsed.
- Decoded outputs:
  - `set_en` = (state==SET);
  - `run_en` = (state==RUN);
  - `field` holds its value outside SET/SET_REL.

## Timing
- All outputs are registered or decoded from registered state, with no combinational path from inputs.
- Reset values: `state`=0, `field`=0, `set_en`=0, `run_en`=0, `flash_on`=0, `done`=0.
- Every transition takes effect on the clk after the qualifying input is sampled, i.e. 1-cycle latency.
- FLASH with auto-exit lasts exactly FLASH_TOGGLES×FLASH_CYCLES cycles. `flash_on` pattern starts at 1 and alternates each FLASH_CYCLES.
- `done` is high for exactly the first IDLE cycle after auto-exit.
- `key_clr` or `rst_n` held low keeps the block in IDLE indefinitely. Release yields SET one cycle later.
- Reset mid-FLASH, mid-RUN or mid-SET_REL discards all progress, and no `done` is pulsed.

## Test plan
- Reset then release (NUM_FIELDS=3): `rst_n` 0→1 with keys idle → state 1 next cycle, `field`=0. Three `key_sel` press/release pairs → `field` 0→1→2, then state 3.
- Run/pause: in READY, press/release `key_run` → 4 then 5, `run_en`=1. Press/release again → 6 then 3, `run_en`=0. Pressing in RUN while `finish`=1 in the same cycle → 6, not 7.
- Flash auto-exit (FLASH_CYCLES=4, FLASH_TOGGLES=4): `finish`=1 in RUN at cycle t → state 7 with `flash_on`=1 at t+1..t+4, 0 at t+5..t+8, 1 at t+9..t+12, 0 at t+13..t+16. At t+17, state 0 with `done`=1. At t+18, state 1 and `done`=0.
- Acknowledge (FLASH_TOGGLES=0): flash runs >100 cycles. `key_run` pressed → 8 with `flash_on`=0. Release → 0 then 1. `done` never asserts.
- Clear priority: `key_clr`=0 asserted during RUN_REL, SET_REL and FLASH → state 0 next cycle with `field`=0. Hold 10 cycles → remains 0. Release → 1.
- READY re-edit: in READY, press `key_sel` → state 2 with `field`=NUM_FIELDS-1. Release → 3. Pressing `key_sel` and `key_run` together in READY → 4.
